fifo_wr_gen: RTL and testbench

- Write-side stage of the IP FIFO demo; sits directly upstream of the FIFO and feeds the read-side consumer.
- Lives in the write clock domain; fills the FIFO with a continuous incrementing data pattern.
- Starts a fill burst only after seeing the read-domain empty flag, then writes until the FIFO is exactly full.
- Reports burst count, busy and sticky overflow status for debug.

---
 rtl/fifo_demo_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/fifo_wr_gen.sv | 132 +++++++++++++
 tb/tb_fifo_wr_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_demo_pkg.sv
// Purpose: shared types and constants for the IP FIFO demo write/read stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_demo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } wr_state_e;

    localparam int DATA_W_DEF  = 8;
    localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for a single level signal crossing into clk.
// Latency: 2-3 clk cycles depending on input arrival phase.
// Backpressure: none; level signal, no handshake.
//
// Ports: clk (destination clock), rst_n (async active-low, clears to 0),
//        d (asynchronous input), q (synchronised output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_wr_gen.sv
// Purpose: fills the demo FIFO with an incrementing pattern, one burst per observed empty.
// Latency: first write 2-3 (sync) + 1 + FILL_DELAY wr_clk cycles after empty rises.
// Backpressure: stops on almost_full (last slot written), aborts on full or wr_rst_busy.
//
// Ports: wr_clk, rst_n (async active-low); empty (read domain, synchronised here),
//        almost_full / full / wr_rst_busy (wr_clk domain); fifo_wr_en / fifo_wr_data
//        (registered write port); burst_cnt, busy, overflow_err (debug status).
module fifo_wr_gen
    import fifo_demo_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] START_VAL  = '0,
    parameter int                FILL_DELAY = 10
) (
    input  logic                   wr_clk,
    input  logic                   rst_n,
    input  logic                   empty,
    input  logic                   almost_full,
    input  logic                   full,
    input  logic                   wr_rst_busy,
    output logic                   fifo_wr_en,
    output logic [DATA_W-1:0]      fifo_wr_data,
    output logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   busy,
    output logic                   overflow_err
);

    localparam int              CNT_W    = (FILL_DELAY > 1) ? $clog2(FILL_DELAY) : 1;
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(FILL_DELAY - 1);

    wr_state_e              state, state_nxt;
    logic                   empty_s;
    logic                   armed, armed_nxt;
    logic [CNT_W-1:0]       dly_cnt, dly_nxt;
    logic                   wr_en_nxt;
    logic [DATA_W-1:0]      data_nxt;
    logic [BURST_CNT_W-1:0] burst_nxt;
    logic                   ovf_nxt;

    sync_2ff u_empty_sync (
        .clk   (wr_clk),
        .rst_n (rst_n),
        .d     (empty),
        .q     (empty_s)
    );

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= START_VAL;
            burst_cnt    <= '0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
            dly_cnt      <= '0;
            armed        <= 1'b1;
        end else begin
            state        <= state_nxt;
            fifo_wr_en   <= wr_en_nxt;
            fifo_wr_data <= data_nxt;
            burst_cnt    <= burst_nxt;
            busy         <= (state_nxt != IDLE);
            overflow_err <= ovf_nxt;
            dly_cnt      <= dly_nxt;
            armed        <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en_nxt = fifo_wr_en;
        data_nxt  = fifo_wr_data;
        burst_nxt = burst_cnt;
        ovf_nxt   = overflow_err;
        dly_nxt   = dly_cnt;
        armed_nxt = armed;

        case (state)
            IDLE: begin
                wr_en_nxt = 1'b0;
                // empty_s stays high for a few cycles after a burst fills the
                // FIFO; only a low sample re-arms the trigger.
                if (!empty_s) begin
                    armed_nxt = 1'b1;
                end
                if (armed && empty_s && !wr_rst_busy) begin
                    state_nxt = WAIT;
                    dly_nxt   = DLY_LOAD;
                end
            end

            WAIT: begin
                if (wr_rst_busy) begin
                    state_nxt = IDLE;
                end else if (dly_cnt == '0) begin
                    state_nxt = WRITE;
                    wr_en_nxt = 1'b1;
                    armed_nxt = 1'b0;
                end else begin
                    dly_nxt = dly_cnt - CNT_W'(1);
                end
            end

            WRITE: begin
                // wr_rst_busy beats full beats almost_full.
                if (wr_rst_busy) begin
                    state_nxt = IDLE;
                    wr_en_nxt = 1'b0;
                    armed_nxt = 1'b1;
                end else if (full) begin
                    state_nxt = IDLE;
                    wr_en_nxt = 1'b0;
                    ovf_nxt   = 1'b1;
                end else begin
                    data_nxt = fifo_wr_data + DATA_W'(1);
                    // almost_full: this write takes the last slot, then stop.
                    if (almost_full) begin
                        state_nxt = IDLE;
                        wr_en_nxt = 1'b0;
                        burst_nxt = burst_cnt + BURST_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                wr_en_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Purpose: self-checking bench for fifo_wr_gen against a depth-16 FIFO model
//          with a read side on an unrelated clock; a second instance with
//          START_VAL=0xF8 runs in lockstep to cover data wrap.
module tb_fifo_wr_gen;

    localparam int DEPTH = 16;

    logic        wr_clk = 1'b0;
    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        wr_rst_busy = 1'b0;
    logic        force_full  = 1'b0;
    logic        rd_en       = 1'b0;
    logic        empty, almost_full, full, acc;

    logic        fifo_wr_en, w_wr_en;
    logic [7:0]  fifo_wr_data, w_wr_data;
    logic [15:0] burst_cnt, w_burst_cnt;
    logic        busy, w_busy, overflow_err, w_ovf;

    // FIFO model: occupancy = writes accepted - reads done.
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int exp_idx = 0;
    int n_checks = 0;
    int n_fail   = 0;

    assign empty       = (wr_cnt == rd_cnt);
    assign almost_full = ((wr_cnt - rd_cnt) >= DEPTH - 1);
    assign full        = force_full || ((wr_cnt - rd_cnt) >= DEPTH);
    assign acc         = fifo_wr_en && !full && !wr_rst_busy;

    fifo_wr_gen #(.DATA_W(8), .START_VAL(8'h00), .FILL_DELAY(10)) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .empty(empty), .almost_full(almost_full),
        .full(full), .wr_rst_busy(wr_rst_busy), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .burst_cnt(burst_cnt), .busy(busy),
        .overflow_err(overflow_err)
    );

    fifo_wr_gen #(.DATA_W(8), .START_VAL(8'hF8), .FILL_DELAY(10)) dut_w (
        .wr_clk(wr_clk), .rst_n(rst_n), .empty(empty), .almost_full(almost_full),
        .full(full), .wr_rst_busy(wr_rst_busy), .fifo_wr_en(w_wr_en),
        .fifo_wr_data(w_wr_data), .burst_cnt(w_burst_cnt), .busy(w_busy),
        .overflow_err(w_ovf)
    );

    // wr edges at multiples of 10, rd posedges at 11+14k: never coincident.
    initial forever #10 wr_clk = ~wr_clk;
    initial begin
        #4;
        forever #7 rd_clk = ~rd_clk;
    end

    always @(posedge wr_clk) if (acc) wr_cnt <= wr_cnt + 1;

    always @(posedge rd_clk)
        if (rd_en && (wr_cnt != rd_cnt) && ($urandom_range(3) != 0)) rd_cnt <= rd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Every accepted write must carry the next value of the running sequence.
    always @(negedge wr_clk) begin
        if (acc) begin
            chk("wr_data", 32'(fifo_wr_data), 32'(8'(exp_idx)));
            chk("wr_data_wrap", 32'(w_wr_data), 32'(8'(8'hF8 + exp_idx)));
            exp_idx++;
        end
    end

    task automatic wait_en(input logic v, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(posedge wr_clk);
            #1;
            if (fifo_wr_en === v) break;
        end
        chk(tag, 32'(fifo_wr_en), 32'(v));
    endtask

    task automatic drain(input string tag);
        rd_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge wr_clk);
            if (empty) break;
        end
        rd_en = 1'b0;
        chk(tag, 32'(empty), 1);
    endtask

    task automatic run_burst(input string tag, output int nwr);
        int s;
        s = wr_cnt;
        wait_en(1'b1, 300, {tag, "_start"});
        wait_en(1'b0, 100, {tag, "_end"});
        nwr = wr_cnt - s;
    endtask

    initial begin
        int n, s, k, nwr, exp_burst;
        n = 0;
        exp_burst = 0;

        repeat (3) @(negedge wr_clk);
        chk("rst_wr_en",   32'(fifo_wr_en), 0);
        chk("rst_data",    32'(fifo_wr_data), 0);
        chk("rst_data_w",  32'(w_wr_data), 32'h0F8);
        chk("rst_burst",   32'(burst_cnt), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_ovf",     32'(overflow_err), 0);

        // Burst 1: latency from reset release with empty already high.
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge wr_clk);
            #1;
            if (fifo_wr_en) begin
                n = i;
                break;
            end
        end
        chk("first_wr_latency_13_14", 32'((n == 13) || (n == 14)), 1);
        chk("busy_in_write", 32'(busy), 1);
        wait_en(1'b0, 100, "burst1_end");
        exp_burst = 1;
        chk("burst1_writes", wr_cnt, DEPTH);
        chk("burst1_cnt",    32'(burst_cnt), 32'(exp_burst));
        chk("burst1_ovf",    32'(overflow_err), 0);
        chk("burst1_busy",   32'(busy), 0);

        // Full FIFO, no reads: no restart.
        s = wr_cnt;
        repeat (40) @(negedge wr_clk);
        chk("no_restart_writes", wr_cnt - s, 0);
        chk("no_restart_burst",  32'(burst_cnt), 32'(exp_burst));

        // Burst 2 after drain: data continues at 0x10.
        drain("drain2");
        run_burst("burst2", nwr);
        exp_burst = 2;
        chk("burst2_writes", nwr, DEPTH);
        chk("burst2_cnt",    32'(burst_cnt), 32'(exp_burst));
        chk("burst2_next",   32'(fifo_wr_data), 32'(8'(exp_idx)));

        // Async reset mid-WRITE, dropped between clock edges.
        drain("drain3");
        wait_en(1'b1, 300, "burst3_start");
        k = int'($urandom_range(10, 2));
        repeat (k) @(posedge wr_clk);
        @(negedge wr_clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_wr_en",  32'(fifo_wr_en), 0);
        chk("arst_data",   32'(fifo_wr_data), 0);
        chk("arst_data_w", 32'(w_wr_data), 32'h0F8);
        chk("arst_burst",  32'(burst_cnt), 0);
        chk("arst_ovf",    32'(overflow_err), 0);
        chk("arst_busy",   32'(busy), 0);
        exp_idx = 0;
        exp_burst = 0;
        drain("drain_in_reset");
        @(negedge wr_clk);
        rst_n = 1'b1;

        // Overflow: force full during the 5th write of the burst.
        wait_en(1'b1, 300, "burst4_start");
        s = wr_cnt;
        for (int i = 0; i < 100; i++) begin
            if (wr_cnt - s == 4) break;
            @(posedge wr_clk);
            #1;
        end
        force_full = 1'b1;
        @(posedge wr_clk);
        #1;
        chk("ovf_set",    32'(overflow_err), 1);
        chk("ovf_wr_en",  32'(fifo_wr_en), 0);
        chk("ovf_data",   32'(fifo_wr_data), 32'h04);
        chk("ovf_burst",  32'(burst_cnt), 32'(exp_burst));
        chk("ovf_writes", wr_cnt - s, 4);
        repeat (3) @(negedge wr_clk);
        force_full = 1'b0;
        drain("drain5");
        run_burst("burst5", nwr);
        exp_burst = 1;
        chk("burst5_writes", nwr, DEPTH);
        chk("burst5_cnt",    32'(burst_cnt), 32'(exp_burst));
        chk("ovf_sticky",    32'(overflow_err), 1);

        // wr_rst_busy for 4 cycles mid-WRITE.
        drain("drain6");
        wait_en(1'b1, 300, "burst6_start");
        k = int'($urandom_range(8, 2));
        s = wr_cnt;
        for (int i = 0; i < 100; i++) begin
            if (wr_cnt - s == k) break;
            @(posedge wr_clk);
            #1;
        end
        wr_rst_busy = 1'b1;
        s = wr_cnt;
        @(posedge wr_clk);
        #1;
        chk("rstbusy_wr_en", 32'(fifo_wr_en), 0);
        chk("rstbusy_busy",  32'(busy), 0);
        repeat (3) @(posedge wr_clk);
        #1;
        wr_rst_busy = 1'b0;
        chk("rstbusy_no_writes", wr_cnt - s, 0);
        chk("rstbusy_burst",     32'(burst_cnt), 32'(exp_burst));
        drain("drain7");
        run_burst("burst7", nwr);
        exp_burst = 2;
        chk("burst7_writes", nwr, DEPTH);
        chk("burst7_cnt",    32'(burst_cnt), 32'(exp_burst));

        chk("wrap_burst", 32'(w_burst_cnt), 32'(exp_burst));
        chk("wrap_ovf",   32'(w_ovf), 1);
        chk("wrap_wr_en", 32'(w_wr_en), 0);
        chk("wrap_busy",  32'(w_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
